// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scanner with a double-buffered display word.
// Optional feature: define SEG_LZB_EN for leading-zero blanking at frame apply.
module seg_scan_driver #(
  parameter int DIGITS     = 8,
  parameter int DIV        = 100000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  load,
  output logic                  pending,
  output logic                  frame,
  output logic [7:0]            SEG,
  output logic [DIGITS-1:0]     AN
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [7:0]        SEG_OFF  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AN_OFF   = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*DIGITS-1:0]   cap_data_q, cap_data_d, sh_data_q, sh_data_d;
  logic [DIGITS-1:0]     cap_dp_q, cap_dp_d, sh_dp_q, sh_dp_d;
  logic [DIGITS-1:0]     cap_blank_q, cap_blank_d, sh_blank_q, sh_blank_d;
  logic                  pending_q, pending_d;
  logic                  frame_q, frame_d;
  logic [7:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     an_q, an_d;

  logic                  wrap, apply;
  logic [3:0]            nib;
  logic [7:0]            seg_act;
  logic [DIGITS-1:0]     an_act;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

`ifdef SEG_LZB_EN
  // Blank from the top digit down until a nonzero nibble or a lit dp; digit 0 always shows.
  function automatic logic [DIGITS-1:0] lzb_mask(input logic [4*DIGITS-1:0] d,
                                                 input logic [DIGITS-1:0]   dp);
    logic [DIGITS-1:0] m;
    logic              run;
    m   = '0;
    run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if ((d[4*k +: 4] != 4'h0) || dp[k]) run = 1'b0;
      m[k] = run;
    end
    return m;
  endfunction
`endif

  always_comb begin
    wrap  = (div_cnt_q == DIV_LAST) && (idx_q == IDX_LAST);
    apply = wrap && pending_q;

    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
    idx_d     = idx_q;
    if (div_cnt_q == DIV_LAST) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

    cap_data_d  = load ? data       : cap_data_q;
    cap_dp_d    = load ? dp_mask    : cap_dp_q;
    cap_blank_d = load ? blank_mask : cap_blank_q;
    // A load on the applying wrap keeps pending set for the word it just captured.
    pending_d   = load | (pending_q & ~apply);

    sh_data_d  = sh_data_q;
    sh_dp_d    = sh_dp_q;
    sh_blank_d = sh_blank_q;
    if (apply) begin
      sh_data_d  = cap_data_q;
      sh_dp_d    = cap_dp_q;
`ifdef SEG_LZB_EN
      sh_blank_d = cap_blank_q | lzb_mask(cap_data_q, cap_dp_q);
`else
      sh_blank_d = cap_blank_q;
`endif
    end

    nib     = sh_data_q[{idx_q, 2'b00} +: 4];
    seg_act = {sh_dp_q[idx_q], hex_to_seg(nib)};
    an_act  = DIGITS'(1) << idx_q;
    if (sh_blank_q[idx_q]) begin
      seg_act = '0;
      an_act  = '0;
    end
    seg_d   = (ACTIVE_LOW != 0) ? ~seg_act : seg_act;
    an_d    = (ACTIVE_LOW != 0) ? ~an_act  : an_act;
    frame_d = wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q   <= '0;
      idx_q       <= '0;
      cap_data_q  <= '0;
      cap_dp_q    <= '0;
      cap_blank_q <= '0;
      sh_data_q   <= '0;
      sh_dp_q     <= '0;
      sh_blank_q  <= '0;
      pending_q   <= 1'b0;
      frame_q     <= 1'b0;
      seg_q       <= SEG_OFF;
      an_q        <= AN_OFF;
    end else begin
      div_cnt_q   <= div_cnt_d;
      idx_q       <= idx_d;
      cap_data_q  <= cap_data_d;
      cap_dp_q    <= cap_dp_d;
      cap_blank_q <= cap_blank_d;
      sh_data_q   <= sh_data_d;
      sh_dp_q     <= sh_dp_d;
      sh_blank_q  <= sh_blank_d;
      pending_q   <= pending_d;
      frame_q     <= frame_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign pending = pending_q;
  assign frame   = frame_q;
  assign SEG     = seg_q;
  assign AN      = an_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (DIGITS=4, DIV=3, active-low outputs).
module tb_seg_scan_driver;
  localparam int DIGITS = 4;
  localparam int DIV    = 3;
  localparam int NFRM   = DIGITS * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = '0;
  logic [3:0]  dp_mask = '0;
  logic [3:0]  blank_mask = '0;
  logic        load = 1'b0;
  logic        pending, frame;
  logic [7:0]  SEG;
  logic [3:0]  AN;

  seg_scan_driver #(.DIGITS(DIGITS), .DIV(DIV), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .data(data), .dp_mask(dp_mask), .blank_mask(blank_mask),
    .load(load), .pending(pending), .frame(frame), .SEG(SEG), .AN(AN)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] an;
    logic       frm;
    logic       pend;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Active-low glyphs, dp (bit 7) off.
  logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference state: position within the frame and the two display buffers.
  int          m_pos;
  logic [15:0] m_sh_d, m_cap_d;
  logic [3:0]  m_sh_dp, m_sh_bl, m_cap_dp, m_cap_bl;
  logic        m_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_lzb(input logic [15:0] d, input logic [3:0] dp);
    logic [3:0] m;
    m = 4'b0000;
`ifdef SEG_LZB_EN
    if (d[15:12] == 0 && !dp[3]) begin
      m[3] = 1'b1;
      if (d[11:8] == 0 && !dp[2]) begin
        m[2] = 1'b1;
        if (d[7:4] == 0 && !dp[1]) m[1] = 1'b1;
      end
    end
`endif
    return m;
  endfunction

  task automatic step(input logic r, input logic ld, input logic [15:0] d,
                      input logic [3:0] dp, input logic [3:0] bl);
    exp_t e;
    int   dig;
    logic wr;
    rst = r; load = ld; data = d; dp_mask = dp; blank_mask = bl;
    if (r) begin
      e = '{seg: 8'hFF, an: 4'hF, frm: 1'b0, pend: 1'b0};
      m_pos = 0; m_sh_d = '0; m_sh_dp = '0; m_sh_bl = '0;
      m_cap_d = '0; m_cap_dp = '0; m_cap_bl = '0; m_pend = 1'b0;
    end else begin
      dig = m_pos / DIV;
      wr  = (m_pos == NFRM - 1);
      if (m_sh_bl[dig]) begin
        e.seg = 8'hFF;
        e.an  = 4'hF;
      end else begin
        e.seg = glyph[m_sh_d[4*dig +: 4]];
        if (m_sh_dp[dig]) e.seg[7] = 1'b0;
        e.an  = ~(4'b0001 << dig);
      end
      e.frm = wr;
      if (wr && m_pend) begin
        m_sh_d = m_cap_d; m_sh_dp = m_cap_dp;
        m_sh_bl = m_cap_bl | ref_lzb(m_cap_d, m_cap_dp);
        m_pend = 1'b0;
      end
      if (ld) begin
        m_cap_d = d; m_cap_dp = dp; m_cap_bl = bl; m_pend = 1'b1;
      end
      e.pend = m_pend;
      m_pos = (m_pos + 1) % NFRM;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("seg",     32'(SEG),     32'(e.seg));
    check("an",      32'(AN),      32'(e.an));
    check("frame",   32'(frame),   32'(e.frm));
    check("pending", 32'(pending), 32'(e.pend));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
  endtask

  task automatic until_wrap;
    for (int i = 0; i < NFRM && m_pos != NFRM - 1; i++) step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
  endtask

  initial begin
    step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    idle(26);
    step(1'b0, 1'b1, 16'h12AF, 4'b0100, 4'b0000);
    idle(30);
    step(1'b0, 1'b1, 16'h1111, 4'b0000, 4'b0000);
    idle(2);
    step(1'b0, 1'b1, 16'h2222, 4'b0000, 4'b0000);
    idle(26);
    until_wrap();
    step(1'b0, 1'b1, 16'h3333, 4'b0001, 4'b0000);
    idle(26);
    step(1'b0, 1'b1, 16'h4567, 4'b0000, 4'b1010);
    idle(26);
    step(1'b0, 1'b1, 16'h0050, 4'b0000, 4'b0000);
    idle(26);
    step(1'b0, 1'b1, 16'h0000, 4'b0000, 4'b0000);
    idle(26);
    step(1'b0, 1'b1, 16'h89CD, 4'b1000, 4'b0000);
    idle(2);
    step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    idle(28);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
